// File: rtl/xor2_bist_pkg.sv
// Shared types and constants for the XOR2 built-in self-test sequencer.
package xor2_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_DONE
   } state_e;

   // Vectors are applied as {a,b} = index, walking 00, 01, 10, 11.
   localparam int          VEC_CNT   = 4;
   localparam logic [1:0]  VEC_FIRST = 2'd0;
   localparam logic [1:0]  VEC_LAST  = 2'(VEC_CNT - 1);

   // Expected gate output per vector index: bit i = a^b for {a,b} = i.
   localparam logic [VEC_CNT-1:0] EXP_TABLE = 4'b0110;

   function automatic logic exp_c(input logic [1:0] idx);
      return EXP_TABLE[idx];
   endfunction

endpackage

// File: rtl/xor2_bist_ctrl_if.sv
// Gate drive, gate observation and status signals between the BIST
// controller (master) and the gate / configuration logic (slave).
interface xor2_bist_ctrl_if;
   import xor2_bist_pkg::*;

   logic               start;
   logic               abort;
   logic               a;
   logic               b;
   logic               c;
   logic               busy;
   logic               done;
   logic               pass;
   logic [VEC_CNT-1:0] fail_vec;

   modport master (
      input  start, abort, c,
      output a, b, busy, done, pass, fail_vec
   );

   modport slave (
      output start, abort, c,
      input  a, b, busy, done, pass, fail_vec
   );

endinterface

// File: rtl/xor2_dwell_timer.sv
// Dwell counter: counts cycles a vector has been held and flags the last one.
module xor2_dwell_timer #(
   parameter int DWELL = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = $clog2(DWELL + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins over increment.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + CW'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == CW'(DWELL - 1));

endmodule

// File: rtl/xor2_bist_ctrl.sv
// BIST sequencer for an XOR2 gate: applies the four input vectors, samples
// the gate output at the end of each dwell and reports per-vector results.
module xor2_bist_ctrl
   import xor2_bist_pkg::*;
#(
   parameter int DWELL = 25
) (
   input  logic             clk,
   input  logic             rst,
   xor2_bist_ctrl_if.master bus
);

   state_e             state_q,    state_d;
   logic [1:0]         idx_q,      idx_d;
   logic [1:0]         ab_q,       ab_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               pass_q,     pass_d;
   logic [VEC_CNT-1:0] fail_vec_q, fail_vec_d;

   logic tmr_clr;
   logic tmr_en;
   logic tmr_last;

   xor2_dwell_timer #(
      .DWELL (DWELL)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .en   (tmr_en),
      .last (tmr_last)
   );

   // Next-state, vector sequencing and result accumulation.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      ab_d       = ab_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      fail_vec_d = fail_vec_q;
      tmr_clr    = 1'b1;
      tmr_en     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            ab_d   = VEC_FIRST;
            busy_d = 1'b0;
            if (bus.start) begin
               state_d    = ST_APPLY;
               idx_d      = VEC_FIRST;
               busy_d     = 1'b1;
               fail_vec_d = '0;
               pass_d     = 1'b0;
            end
         end

         ST_APPLY: begin
            tmr_en  = 1'b1;
            tmr_clr = tmr_last;
            if (bus.abort) begin
               // Abort takes precedence over a coincident final sample.
               state_d    = ST_IDLE;
               idx_d      = VEC_FIRST;
               ab_d       = VEC_FIRST;
               busy_d     = 1'b0;
               fail_vec_d = '0;
               pass_d     = 1'b0;
               tmr_clr    = 1'b1;
            end else if (tmr_last) begin
               // c is only looked at on the last dwell cycle, after settling.
               if (bus.c != exp_c(idx_q)) begin
                  fail_vec_d[idx_q] = 1'b1;
               end
               if (idx_q == VEC_LAST) begin
                  state_d = ST_DONE;
                  idx_d   = VEC_FIRST;
                  ab_d    = VEC_FIRST;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (fail_vec_d == '0);
               end else begin
                  idx_d = idx_q + 2'd1;
                  ab_d  = idx_q + 2'd1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= VEC_FIRST;
         ab_q       <= VEC_FIRST;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_vec_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ab_q       <= ab_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_vec_q <= fail_vec_d;
      end
   end

   assign bus.a        = ab_q[1];
   assign bus.b        = ab_q[0];
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.fail_vec = fail_vec_q;

endmodule
